// File: rtl/csa_accumulator.sv
// csa_accumulator: accumulates a packet of unsigned operands in carry-save
// form (one 3:2 compression per beat) and resolves the redundant sum with a
// single carry-propagate add once the last beat has arrived.
// Optional feature: define CSA_ACC_OVF_EN to add the sticky overflow flag and
// the out_ovf port; without it, the port and all overflow logic are absent.
module csa_accumulator #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0] out_count
`ifdef CSA_ACC_OVF_EN
  ,
  output logic                 out_ovf
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCUM   = 2'd1,
    S_RESOLVE = 2'd2,
    S_OUTPUT  = 2'd3
  } state_t;

  state_t               r_state;
  logic [ACC_WIDTH-1:0] r_s;
  logic [ACC_WIDTH-1:0] r_c;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [ACC_WIDTH-1:0] r_out_data;
  logic [CNT_WIDTH-1:0] r_out_count;

  logic                 w_accept;
  logic                 w_first;
  logic [ACC_WIDTH-1:0] w_x;
  logic [ACC_WIDTH-1:0] w_s_in;
  logic [ACC_WIDTH-1:0] w_c_in;
  logic [ACC_WIDTH-1:0] w_maj;
  logic [ACC_WIDTH-1:0] w_s_next;
  logic [ACC_WIDTH-1:0] w_c_next;
  logic [ACC_WIDTH-1:0] w_sum;
  logic [CNT_WIDTH-1:0] w_count_next;

  // in_ready is a register so that it reads 0 throughout reset and rises on
  // the first clock edge after release.
  assign w_accept = in_valid & r_in_ready;
  assign w_first  = (r_state == S_IDLE);

  // A packet's first beat compresses against zero regardless of S/C contents.
  assign w_x    = {{(ACC_WIDTH-WIDTH){1'b0}}, in_data};
  assign w_s_in = w_first ? '0 : r_s;
  assign w_c_in = w_first ? '0 : r_c;

  // 3:2 compressor: sum bits stay in place, majority bits move up one weight;
  // the majority MSB falls off the top (modulo 2^ACC_WIDTH).
  assign w_maj    = (w_s_in & w_c_in) | (w_s_in & w_x) | (w_c_in & w_x);
  assign w_s_next = w_s_in ^ w_c_in ^ w_x;
  assign w_c_next = w_maj << 1;

  assign w_count_next = w_first ? CNT_WIDTH'(1) : r_count + CNT_WIDTH'(1);

`ifdef CSA_ACC_OVF_EN
  logic r_ovf;
  logic r_out_ovf;
  logic w_sum_co;
  logic w_ovf_next;

  // Carry-out of the resolve add is the second way a packet can overflow.
  assign {w_sum_co, w_sum} = {1'b0, r_s} + {1'b0, r_c};
  assign w_ovf_next        = (w_first ? 1'b0 : r_ovf) | w_maj[ACC_WIDTH-1];
  assign out_ovf           = r_out_ovf;
`else
  assign w_sum = r_s + r_c;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;

  // Packet FSM: accumulate beats, resolve for one cycle, hold result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_s         <= '0;
      r_c         <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
`ifdef CSA_ACC_OVF_EN
      r_ovf       <= 1'b0;
      r_out_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_s     <= w_s_next;
            r_c     <= w_c_next;
            r_count <= w_count_next;
`ifdef CSA_ACC_OVF_EN
            r_ovf   <= w_ovf_next;
`endif
            if (in_last) begin
              r_state    <= S_RESOLVE;
              r_in_ready <= 1'b0;
            end else begin
              r_state    <= S_ACCUM;
            end
          end
        end
        S_RESOLVE: begin
          r_out_data  <= w_sum;
          r_out_count <= r_count;
`ifdef CSA_ACC_OVF_EN
          r_out_ovf   <= r_ovf | w_sum_co;
`endif
          r_out_valid <= 1'b1;
          r_state     <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (out_ready) begin
            r_s         <= '0;
            r_c         <= '0;
            r_count     <= '0;
`ifdef CSA_ACC_OVF_EN
            r_ovf       <= 1'b0;
`endif
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator (WIDTH=4, ACC_WIDTH=8, CNT_WIDTH=4).
// Overflow checks are included when CSA_ACC_OVF_EN is defined.
module tb_csa_accumulator;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_count;
`ifdef CSA_ACC_OVF_EN
  logic       out_ovf;
`endif

  csa_accumulator #(.WIDTH(4), .ACC_WIDTH(8), .CNT_WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
`ifdef CSA_ACC_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [3:0] data;
    logic       last;
    int         gap;
    logic [7:0] exp_data;
    logic [3:0] exp_cnt;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void add(input logic [3:0] d, input logic l, input int g,
                              input logic [7:0] ed, input logic [3:0] ec, input logic eo);
    vec_t v;
    v.data = d; v.last = l; v.gap = g;
    v.exp_data = ed; v.exp_cnt = ec; v.exp_ovf = eo;
    vecs.push_back(v);
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_beat(input logic [3:0] d, input logic l);
    int n;
    in_valid = 1'b1; in_data = d; in_last = l;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL accept_timeout: in_ready stayed 0 for beat %0d", d);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    $display("beat data=%0d last=%0d accepted", d, l);
  endtask

  // Called right after the last beat with out_ready=1: checks fixed latency,
  // result values and the return to IDLE.
  task automatic check_result(input string name, input logic [7:0] ed,
                              input logic [3:0] ec, input logic eo);
    check({name, "_resolve_valid"}, {31'd0, out_valid}, 32'd0);
    check({name, "_resolve_ready"}, {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({name, "_data"},  {24'd0, out_data},  {24'd0, ed});
    check({name, "_count"}, {28'd0, out_count}, {28'd0, ec});
`ifdef CSA_ACC_OVF_EN
    check({name, "_ovf"},   {31'd0, out_ovf},   {31'd0, eo});
`else
    if (eo === 1'bx) $display("unused");
`endif
    $display("packet %s: data=%0d count=%0d", name, out_data, out_count);
    @(negedge clk);
    check({name, "_done_valid"}, {31'd0, out_valid}, 32'd0);
    check({name, "_done_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;

    // Vector table: expected values attached to each packet's last beat.
    add(15, 0, 0, 0, 0, 0); add(15, 0, 0, 0, 0, 0); add(15, 1, 0, 45, 3, 0);
    add(9, 1, 0, 9, 1, 0);
    for (int i = 0; i < 19; i++) add(15, 0, 0, 0, 0, 0);
    add(15, 1, 0, 44, 4, 1);
    add(1, 0, 0, 0, 0, 0); add(2, 1, 0, 3, 2, 0);
    add(7, 0, 0, 0, 0, 0); add(8, 0, 3, 0, 0, 0); add(1, 1, 3, 16, 3, 0);
    for (int i = 0; i < 16; i++) add(15, 0, 0, 0, 0, 0);
    add(15, 1, 0, 255, 1, 0);
    add(0, 1, 0, 0, 1, 0);
    add(10, 0, 1, 0, 0, 0); add(5, 1, 2, 15, 2, 0);

    // Reset state, before and just after release.
    #1;
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {24'd0, out_data},  32'd0);
    check("rst_out_count", {28'd0, out_count}, 32'd0);
`ifdef CSA_ACC_OVF_EN
    check("rst_out_ovf",   {31'd0, out_ovf},   32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    check("release_ready_pre", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("release_ready_post", {31'd0, in_ready}, 32'd1);

    // Table-driven packets.
    for (int i = 0; i < vecs.size(); i++) begin
      repeat (vecs[i].gap) @(negedge clk);
      send_beat(vecs[i].data, vecs[i].last);
      if (vecs[i].last)
        check_result($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_cnt, vecs[i].exp_ovf);
    end

    // Backpressure: out_ready low for 5 OUTPUT cycles with in_valid held high.
    out_ready = 1'b0;
    send_beat(3, 0);
    send_beat(4, 1);
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'd15; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_valid", k), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp%0d_data", k),  {24'd0, out_data},  32'd7);
      check($sformatf("bp%0d_count", k), {28'd0, out_count}, 32'd2);
      check($sformatf("bp%0d_ready", k), {31'd0, in_ready},  32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_after_valid", {31'd0, out_valid}, 32'd0);
    check("bp_after_ready", {31'd0, in_ready},  32'd1);
    $display("backpressure sequence done");
    send_beat(1, 1);
    check_result("bp_next", 8'd1, 4'd1, 1'b0);

    // Reset mid-packet.
    send_beat(2, 0);
    send_beat(3, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'd0, in_ready},  32'd0);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_data",  {24'd0, out_data},  32'd0);
    check("midrst_count", {28'd0, out_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_beat(5, 0);
    send_beat(6, 1);
    check_result("after_midrst", 8'd11, 4'd2, 1'b0);

    // Reset while a result is being held in OUTPUT.
    out_ready = 1'b0;
    send_beat(9, 1);
    @(negedge clk);
    check("outrst_pre_data", {24'd0, out_data}, 32'd9);
    #2 rst_n = 1'b0;
    #1;
    check("outrst_valid", {31'd0, out_valid}, 32'd0);
    check("outrst_data",  {24'd0, out_data},  32'd0);
    check("outrst_count", {28'd0, out_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    send_beat(4, 0);
    send_beat(4, 1);
    check_result("after_outrst", 8'd8, 4'd2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
